// File: rtl/seq_divider_if.sv
// Handshake and operand/result bus of the repeated-subtraction divider.
interface seq_divider_if;
  logic        start;
  logic [15:0] data_in;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        done;
  logic        busy;
  logic        div_by_zero;

  modport master (
    output start, data_in,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// 16-bit unsigned divider by repeated subtraction; all state updates on the falling clock edge.
module seq_divider (
  input  logic          clock,
  input  logic          reset_n,
  seq_divider_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADA = 3'd1,
    S_LOADB = 3'd2,
    S_SUB   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] r_q, r_d;
  logic [15:0] d_q, d_d;
  logic [15:0] q_q, q_d;
  logic        dbz_q, dbz_d;

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      q_q     <= q_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    q_d     = q_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_LOADA;
      S_LOADA: begin
        r_d     = bus.data_in;
        q_d     = '0;
        dbz_d   = 1'b0;
        state_d = S_LOADB;
      end
      S_LOADB: begin
        d_d = bus.data_in;
        if (bus.data_in == 16'd0) begin
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SUB;
        end
      end
      // Q is bounded by the dividend, so the increment cannot wrap.
      S_SUB: begin
        if (r_q >= d_q) begin
          r_d = r_q - d_q;
          q_d = q_q + 16'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: if (!bus.start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.done        = (state_q == S_DONE);
  assign bus.busy        = (state_q == S_LOADA) || (state_q == S_LOADB) || (state_q == S_SUB);
endmodule

// File: tb/tb_seq_divider.sv
// Directed vectors for seq_divider; results checked by a scoreboard monitor on done rising.
module tb_seq_divider;
  logic clock;
  logic reset_n;
  seq_divider_if bus();

  seq_divider dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;
  logic done_prev = 1'b0;

  always @(negedge clock) ecnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Monitor: a rising done retires the oldest outstanding operation.
  always @(posedge clock) begin
    if (reset_n && bus.done && !done_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient",    {16'd0, bus.quotient},  {16'd0, e.q});
        chk("remainder",   {16'd0, bus.remainder}, {16'd0, e.r});
        chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
        chk("latency",     ecnt - e.e0, e.lat);
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
      end
    end
    done_prev = bus.done;
  end

  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] eq, input logic [15:0] er,
                     input bit hold, input int pulse_at);
    exp_t e;
    bit   got;
    @(posedge clock);
    bus.start = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.dbz = (b == 16'd0);
    e.lat = (b == 16'd0) ? 2 : int'(eq) + 3;
    e.e0  = ecnt + 1;
    sb.push_back(e);
    @(posedge clock);
    chk("busy_after_e0", {31'd0, bus.busy}, 32'd1);
    bus.start   = hold;
    bus.data_in = a;
    @(posedge clock);
    bus.data_in = b;
    @(posedge clock);
    bus.data_in = 16'hDEAD;
    got = 1'b0;
    for (int n = 0; n < 70000; n++) begin
      bus.start = hold || (n == pulse_at);
      if (sb.size() == 0) begin
        got = 1'b1;
        break;
      end
      @(posedge clock);
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = 16'd0;
    repeat (2) @(posedge clock);
    chk("rst_quotient",  {16'd0, bus.quotient},  32'd0);
    chk("rst_remainder", {16'd0, bus.remainder}, 32'd0);
    chk("rst_done",      {31'd0, bus.done},      32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_dbz",       {31'd0, bus.div_by_zero}, 32'd0);
    reset_n = 1'b1;

    run(16'd100,   16'd7, 16'd14,    16'd2, 1'b0, -1);
    run(16'd5,     16'd9, 16'd0,     16'd5, 1'b0, -1);
    run(16'd0,     16'd3, 16'd0,     16'd0, 1'b0, -1);
    run(16'd9,     16'd0, 16'd0,     16'd9, 1'b0, -1);
    run(16'd100,   16'd7, 16'd14,    16'd2, 1'b0, 5);
    run(16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, -1);

    // Start held through DONE keeps results; releasing it returns to IDLE with results retained.
    run(16'd48, 16'd6, 16'd8, 16'd0, 1'b1, -1);
    repeat (3) @(posedge clock);
    chk("hold_done",      {31'd0, bus.done},      32'd1);
    chk("hold_quotient",  {16'd0, bus.quotient},  32'd8);
    chk("hold_remainder", {16'd0, bus.remainder}, 32'd0);
    bus.start = 1'b0;
    repeat (2) @(posedge clock);
    chk("idle_done",      {31'd0, bus.done},      32'd0);
    chk("idle_busy",      {31'd0, bus.busy},      32'd0);
    chk("idle_quotient",  {16'd0, bus.quotient},  32'd8);
    chk("idle_remainder", {16'd0, bus.remainder}, 32'd0);

    // Abort 1000/3 mid-SUB with reset.
    @(posedge clock);
    bus.start = 1'b1;
    @(posedge clock);
    bus.start   = 1'b0;
    bus.data_in = 16'd1000;
    @(posedge clock);
    bus.data_in = 16'd3;
    repeat (20) @(posedge clock);
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_quotient",  {16'd0, bus.quotient},  32'd0);
    chk("abort_remainder", {16'd0, bus.remainder}, 32'd0);
    chk("abort_done",      {31'd0, bus.done},      32'd0);
    chk("abort_busy",      {31'd0, bus.busy},      32'd0);
    @(posedge clock);
    reset_n = 1'b1;

    run(16'd20, 16'd4, 16'd5, 16'd0, 1'b0, -1);
    repeat (3) @(posedge clock);
    chk("final_queue_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
